// File: rtl/step_judge_if.sv
// Bundles the beat inputs and judgement outputs of step_judge into one port.
// The stimulus side (arrow shifter plus pads) uses master; the judge uses slave.
interface step_judge_if;
  logic        stepEn;
  logic [3:0]  actionStep;
  logic [3:0]  pads;
  logic        hit;
  logic        miss;
  logic [11:0] score;
  logic [7:0]  combo;

  modport master (
    output stepEn, actionStep, pads,
    input  hit, miss, score, combo
  );

  modport slave (
    input  stepEn, actionStep, pads,
    output hit, miss, score, combo
  );
endinterface

// File: rtl/step_judge.sv
// step_judge: judges each beat of a rhythm game as a hit or a miss.
// Pads are synchronised and edge detected.  Each press that lands while a beat
// is armed marks its pad as got.  Once every target arrow is got, the beat is a hit.
// A beat whose target is still incomplete when the next stepEn arrives is a miss.
// Compile-time option JUDGE_WRONG_PAD_PENALTY_EN: when defined, pressing a pad
// outside the target (or any pad on an empty beat) is judged a miss at once.
module step_judge (
  input logic        clk,
  input logic        reset,
  step_judge_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ARMED  = 2'd1,
    EMPTY  = 2'd2,
    JUDGED = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  sync1_reg;
  logic [3:0]  sync2_reg;
  logic [3:0]  sync3_reg;
  logic [3:0]  pad_rise;

  logic [3:0]  target_reg;
  logic [3:0]  target_next;
  logic [3:0]  got_reg;
  logic [3:0]  got_next;
  logic [3:0]  got_new;

  logic        judge_hit;
  logic        judge_miss;

  logic        hit_reg;
  logic        miss_reg;
  logic [11:0] score_reg;
  logic [7:0]  combo_reg;

  // Three-digit BCD increment that saturates at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else if (v[7:4] != 4'd9) begin
      r[7:4] = v[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[11:8] = v[11:8] + 4'd1;
      r[7:0]  = 8'h00;
    end
    return r;
  endfunction

  // Per-pad two-flop synchroniser plus one delay flop for rising-edge detection.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
          sync3_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= bus.pads[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          sync3_reg[gi] <= sync2_reg[gi];
        end
      end
      assign pad_rise[gi] = sync2_reg[gi] & ~sync3_reg[gi];
    end
  endgenerate

  assign got_new = got_reg | (pad_rise & target_reg);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.  A new beat always restarts at LOAD.  A judgement without a new beat parks in JUDGED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD: begin
        if (!bus.stepEn) begin
          state_next = (bus.actionStep != 4'b0000) ? ARMED : EMPTY;
        end
      end
      default: begin
        if (bus.stepEn) begin
          state_next = LOAD;
        end else if (judge_hit || judge_miss) begin
          state_next = JUDGED;
        end
      end
    endcase
  end

  // Output/decision logic.  Completion wins over a coincident stepEn, which keeps the window inclusive.
  always_comb begin
    judge_hit   = 1'b0;
    judge_miss  = 1'b0;
    target_next = target_reg;
    got_next    = got_reg;
    case (state_reg)
      LOAD: begin
        target_next = bus.actionStep;
        got_next    = 4'b0000;
      end
      ARMED: begin
        got_next = got_new;
`ifdef JUDGE_WRONG_PAD_PENALTY_EN
        if ((pad_rise & ~target_reg) != 4'b0000) begin
          judge_miss = 1'b1;
        end else if (got_new == target_reg) begin
          judge_hit = 1'b1;
        end else if (bus.stepEn) begin
          judge_miss = 1'b1;
        end
`else
        if (got_new == target_reg) begin
          judge_hit = 1'b1;
        end else if (bus.stepEn) begin
          judge_miss = 1'b1;
        end
`endif
      end
      EMPTY: begin
`ifdef JUDGE_WRONG_PAD_PENALTY_EN
        if (pad_rise != 4'b0000) begin
          judge_miss = 1'b1;
        end
`endif
      end
      default: begin
      end
    endcase
  end

  // Beat datapath and registered result pulses, score and combo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_reg <= 4'b0000;
      got_reg    <= 4'b0000;
      hit_reg    <= 1'b0;
      miss_reg   <= 1'b0;
      score_reg  <= 12'h000;
      combo_reg  <= 8'h00;
    end else begin
      target_reg <= target_next;
      got_reg    <= got_next;
      hit_reg    <= judge_hit;
      miss_reg   <= judge_miss;
      if (judge_hit) begin
        score_reg <= bcd_inc(score_reg);
        if (combo_reg != 8'hFF) begin
          combo_reg <= combo_reg + 8'h01;
        end
      end else if (judge_miss) begin
        combo_reg <= 8'h00;
      end
    end
  end

  assign bus.hit   = hit_reg;
  assign bus.miss  = miss_reg;
  assign bus.score = score_reg;
  assign bus.combo = combo_reg;

endmodule
